fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter that shares the write port of the team's async FIFO between `NUM_REQ` producers in the write clock domain. Each producer offers one word at a time on a req/grant handshake. The arbiter selects one word, registers it, and drives the FIFO's `write_en`/`data_in` pair, never writing while `fifo_full` is high. It also keeps a saturating stall counter for throughput debug.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_WIDTH`, 8: word width; matches the FIFO `data_in`.
- `write_clk` in 1: single clock, the FIFO write clock.
- `reset` in 1: synchronous, active-high.
- `req` in `NUM_REQ`: `req[i]`=1 means producer i offers a word.
- `req_data` in `NUM_REQ*DATA_WIDTH`: producer i word on bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `grant` out `NUM_REQ`: one-hot, combinational; `grant[i]`=1 means producer i's word is taken at this edge.
- `fifo_full` in 1: FIFO full flag, write-clock domain.
- `write_en` out 1: FIFO write strobe, registered.
- `data_in` out `DATA_WIDTH`: FIFO write data, registered.
- `stall_cnt` out 16: saturating count of cycles with any req blocked by `fifo_full`.

## Operation
- State: `last` pointer (`$clog2(NUM_REQ)` bits), registered `write_en`/`data_in`, `stall_cnt`.
- Issue condition: `reset`=0, `fifo_full`=0, `write_en`=0 (no write in flight), `|req`=1.
- Selection:
  - Round-robin search starting at `last+1`, wrapping modulo `NUM_REQ`.
  - The first index with `req` set wins, and `grant` is that one-hot.
  - When the issue condition is false, `grant`=0.
- On a grant to i at an edge:
  - `data_in` <= word i.
  - `write_en` <= 1.
  - `last` <= i.
- Any cycle without a grant: `write_en` <= 0. `data_in` holds its last value.
- Producer rules:
  - Hold `req[i]` and the word stable until the edge where `grant[i]`=1.
  - After that edge, drop `req[i]` or present the next word.
  - Deasserting `req` without a grant is allowed; the word is simply not written.
- Stall counting: increments by 1 per cycle with `|req`=1 and `fifo_full`=1, and saturates at 16'hFFFF. It does not count cycles blocked only by an in-flight write.
- Reset values: `write_en`=0, `data_in`=0, `stall_cnt`=0, `last`=`NUM_REQ-1` (producer 0 has first priority). `grant`=0 while `reset`=1.
- Reset mid-operation:
  - A registered write is dropped; `write_en` is 0 on the cycle after reset is sampled.
  - The pointer returns to `NUM_REQ-1`.
  - Producers must re-request.
- Simultaneous `fifo_full` rise and a pending request: no grant; the stall is counted.

## Timing
- Grant to FIFO write latency: 1 cycle. Grant at cycle t gives `write_en`=1 with the granted word during t+1.
- Throughput: at most one grant every 2 cycles. The in-flight gate lets the FIFO's `fifo_full` update after each write before the next grant.
- `fifo_full` is sampled combinationally in the grant cycle. The FIFO must present `fifo_full` in the write domain within one cycle of a write.
- `grant` depends combinationally on `req`, `fifo_full`, `write_en`, `last` and `reset` only. There is no path from `req_data`.

## Configuration
- `FIFO_ARB_PRIO_EN` defined: producer 0 is strict high priority. When `req[0]`=1 it wins every issue slot. Producers 1..`NUM_REQ-1` round-robin among themselves only when `req[0]`=0. `last` tracks only grants to 1..`NUM_REQ-1`.
- `FIFO_ARB_PRIO_EN` undefined: plain round-robin over all `NUM_REQ` producers as described above.

## Test plan
- Reset: `reset`=1 with `req`=4'b1111 and `fifo_full`=0 for 3 cycles -> `grant`=0, `write_en`=0, `data_in`=8'h00, `stall_cnt`=0 throughout.
- Single producer: `req`=4'b0100, word2=8'hCA -> `grant`=4'b0100 in the same cycle. Next cycle `write_en`=1 and `data_in`=8'hCA. The next `grant[2]` comes no earlier than 2 cycles after the first.
- Fairness: `req`=4'b1111 held, words 8'h10/8'h21/8'h32/8'h43, `fifo_full`=0 -> grants 0,1,2,3,0 on alternate cycles. `data_in` sequence is 10,21,32,43,10.
- Backpressure: `fifo_full`=1 with `req`=4'b0011 for 5 cycles -> no grant, `write_en`=0, `stall_cnt`=5. Drop `fifo_full` -> `grant`=4'b0001 in that cycle.
- Reset mid-operation: assert `reset` the cycle after `grant[1]` -> `write_en` returns to 0 on the following cycle. After release with `req`=4'b0011 -> `grant`=4'b0001 first.
- Macro: with `FIFO_ARB_PRIO_EN`, `req`=4'b1111 -> `grant`=4'b0001 on every issue slot. Then `req`=4'b1110 -> grants 1,2,3,1. Without the macro, the same stimulus gives 0,1,2,3.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for the async FIFO: selects one producer word per
// issue slot, registers it onto write_en/data_in, and keeps a saturating stall count.
// Optional build macro FIFO_ARB_PRIO_EN makes producer 0 strict high priority.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          write_clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          fifo_full,
  output logic                          write_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [15:0]                   stall_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t LAST_RESET = ptr_t'(NUM_REQ - 1);

  ptr_t                  last;
  ptr_t                  grant_idx;
  ptr_t                  cand;
  logic                  found;
  logic                  issue;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The in-flight gate (write_en) spaces grants two cycles apart so fifo_full can
  // reflect the previous write before the next word is taken.
  assign issue = !reset && !fifo_full && !write_en && (|req);

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
`ifdef FIFO_ARB_PRIO_EN
    if (req[0]) begin
      found     = 1'b1;
      grant_idx = '0;
    end else begin
      // Rotate over producers 1..NUM_REQ-1 only, starting just after last.
      for (int k = 1; k < NUM_REQ; k++) begin
        cand = ptr_t'(1 + ((int'(last) - 1 + k) % (NUM_REQ - 1)));
        if (!found && req[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr_t'((int'(last) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
`endif
    if (issue && found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge write_clk) begin
    if (reset) begin
      write_en  <= 1'b0;
      data_in   <= '0;
      stall_cnt <= '0;
      last      <= LAST_RESET;
    end else begin
      write_en <= issue && found;
      if (issue && found) begin
        data_in <= words[grant_idx];
`ifdef FIFO_ARB_PRIO_EN
        if (grant_idx != '0) begin
          last <= grant_idx;
        end
`else
        last <= grant_idx;
`endif
      end
      // Only FIFO backpressure counts; waiting behind an in-flight write does not.
      if ((|req) && fifo_full && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
